// File: rtl/adc_readout_pkg.sv
// Shared definitions for the ADC capture FIFO readout block.
//   SYNC_HDR / SYNC_TRL : framing bytes that open and close every UART frame
//   state_t             : readout FSM state encoding
//   calc_baud_div       : clocks per UART bit, integer-truncated
package adc_readout_pkg;

    localparam logic [7:0] SYNC_HDR = 8'hA5;
    localparam logic [7:0] SYNC_TRL = 8'h5A;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        FILL,
        HDR,
        RD,
        RDWAIT,
        TXH,
        TXL,
        TRL0,
        TRL1,
        TRL2,
        TRL3,
        FIN
    } state_t;

    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/adc_fifo_readout_if.sv
// Read-side connection between the readout controller and the capture FIFO.
//   cap_en     : capture (write) enable level toward the FIFO
//   rden       : one-cycle read strobe per word
//   fifo_full  : FIFO full flag
//   fifo_empty : FIFO empty flag
//   fifo_dout  : read data, valid the cycle after rden
// master = readout controller, slave = FIFO.
interface adc_fifo_readout_if #(
    parameter int DATA_W = 16
) ();

    logic              cap_en;
    logic              rden;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    modport master (
        output cap_en,
        output rden,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_dout
    );

    modport slave (
        input  cap_en,
        input  rden,
        output fifo_full,
        output fifo_empty,
        output fifo_dout
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser.
//   rclk, mr : clock, async active-low reset (tx idles high in reset)
//   data     : byte to send, captured on load
//   load     : one-cycle start request, honoured only while ready
//   ready    : high when no byte is in flight
//   tx       : serial output, start 0, data LSB first, stop 1
// Every bit lasts exactly BAUD_DIV clocks; ready returns the cycle after
// the stop bit ends.
module uart_tx_byte #(
    parameter int BAUD_DIV = 10
) (
    input  logic       rclk,
    input  logic       mr,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

    logic          r_active;
    logic          r_tx;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit_idx;
    logic [CW-1:0] r_baud_cnt;

    // r_shift holds the data bits with the stop bit on top; shifting in 1s
    // keeps the line high once everything has gone out.
    always_ff @(posedge rclk or negedge mr) begin
        if (!mr) begin
            r_active   <= 1'b0;
            r_tx       <= 1'b1;
            r_shift    <= '1;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
        end else if (!r_active) begin
            if (load) begin
                r_active   <= 1'b1;
                r_tx       <= 1'b0;
                r_shift    <= {1'b1, data};
                r_bit_idx  <= '0;
                r_baud_cnt <= BIT_LAST;
            end
        end else if (r_baud_cnt == '0) begin
            if (r_bit_idx == 4'd9) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_tx       <= r_shift[0];
                r_shift    <= {1'b1, r_shift[8:1]};
                r_bit_idx  <= r_bit_idx + 4'd1;
                r_baud_cnt <= BIT_LAST;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
        end
    end

    assign ready = !r_active;
    assign tx    = r_tx;

endmodule

// File: rtl/adc_fifo_readout.sv
// Capture FIFO readout controller.
//   rclk, mr : read-side clock, async active-low master reset
//   start    : one-cycle arm pulse (ignored while busy)
//   fifo     : capture FIFO read port (cap_en, rden, full, empty, dout)
//   uart_tx  : framed 8N1 stream: A5, data bytes (high byte first), 5A,
//              count hi, count lo, XOR of every byte after A5
//   busy     : accepted start until frame end
//   done     : one-cycle pulse at frame end
//   err      : sticky underrun flag, cleared by the next accepted start
//
// state  | meaning
// IDLE   | waiting for start
// ARM    | raise cap_en
// FILL   | hold cap_en until the FIFO is full
// HDR    | send sync header
// RD     | strobe rden, or abort to trailer on empty
// RDWAIT | wait for dout, latch word, update count/checksum
// TXH    | send upper byte
// TXL    | send lower byte, loop or finish
// TRL0-3 | send trailer sync, count hi, count lo, checksum
// FIN    | wait for last byte to leave, pulse done
module adc_fifo_readout
    import adc_readout_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_SAMPLES = 1024,
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200
) (
    input  logic                rclk,
    input  logic                mr,
    input  logic                start,
    adc_fifo_readout_if.master  fifo,
    output logic                uart_tx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam logic [15:0] LAST_COUNT = 16'(NUM_SAMPLES);

    state_t      r_state;
    logic        r_cap_en;
    logic        r_rden;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_rd_ph;
    logic        r_load;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic [15:0] r_count;
    logic [7:0]  r_csum;

    logic        w_tx_ready;
    logic        w_can_load;
    logic [7:0]  w_dout_hi;
    logic [7:0]  w_dout_lo;

    assign w_dout_hi = fifo.fifo_dout[DATA_W-1 -: 8];
    assign w_dout_lo = fifo.fifo_dout[7:0];

    // ready still reads high the cycle after a load was issued, so the
    // pending load masks it to prevent a double launch.
    assign w_can_load = w_tx_ready && !r_load;

    always_ff @(posedge rclk or negedge mr) begin
        if (!mr) begin
            r_state   <= IDLE;
            r_cap_en  <= 1'b0;
            r_rden    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_ph   <= 1'b0;
            r_load    <= 1'b0;
            r_tx_data <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_csum    <= '0;
        end else begin
            r_done <= 1'b0;
            r_load <= 1'b0;
            r_rden <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_count <= '0;
                        r_csum  <= '0;
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    r_cap_en <= 1'b1;
                    r_state  <= FILL;
                end
                FILL: begin
                    if (fifo.fifo_full) begin
                        r_cap_en <= 1'b0;
                        r_state  <= HDR;
                    end
                end
                HDR: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= SYNC_HDR;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    if (fifo.fifo_empty) begin
                        r_err   <= 1'b1;
                        r_state <= TRL0;
                    end else begin
                        r_rden  <= 1'b1;
                        r_rd_ph <= 1'b0;
                        r_state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // first cycle: rden is on the port; second: dout valid
                    if (!r_rd_ph) begin
                        r_rd_ph <= 1'b1;
                    end else begin
                        r_hi    <= w_dout_hi;
                        r_lo    <= w_dout_lo;
                        r_count <= r_count + 16'd1;
                        r_csum  <= r_csum ^ w_dout_hi ^ w_dout_lo;
                        r_state <= TXH;
                    end
                end
                TXH: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= r_hi;
                        r_state   <= TXL;
                    end
                end
                TXL: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= r_lo;
                        r_state   <= (r_count == LAST_COUNT) ? TRL0 : RD;
                    end
                end
                TRL0: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= SYNC_TRL;
                        r_state   <= TRL1;
                    end
                end
                TRL1: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= r_count[15:8];
                        r_state   <= TRL2;
                    end
                end
                TRL2: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= r_count[7:0];
                        r_state   <= TRL3;
                    end
                end
                TRL3: begin
                    if (w_can_load) begin
                        r_load    <= 1'b1;
                        r_tx_data <= r_csum ^ SYNC_TRL ^ r_count[15:8] ^ r_count[7:0];
                        r_state   <= FIN;
                    end
                end
                FIN: begin
                    // frame ends only once the checksum byte has left the line
                    if (w_can_load) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx_byte (
        .rclk  (rclk),
        .mr    (mr),
        .data  (r_tx_data),
        .load  (r_load),
        .ready (w_tx_ready),
        .tx    (uart_tx)
    );

    assign fifo.cap_en = r_cap_en;
    assign fifo.rden   = r_rden;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_adc_fifo_readout.sv
module tb_adc_fifo_readout;

    localparam int NS = 4;

    logic rclk = 1'b0;
    logic mr = 1'b0;
    logic start = 1'b0;
    logic uart_tx, busy, done, err;

    adc_fifo_readout_if #(.DATA_W(16)) fif ();

    adc_fifo_readout #(
        .DATA_W      (16),
        .NUM_SAMPLES (NS),
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000)
    ) dut (
        .rclk    (rclk),
        .mr      (mr),
        .start   (start),
        .fifo    (fif.master),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 rclk = ~rclk;

    // FIFO model: preloaded words, dout one cycle after rden
    logic [15:0] mem [0:7];
    int          n_words = 0;
    int          rd_ptr = 0;
    logic        full_req = 1'b0;
    logic        fifo_clr = 1'b0;

    assign fif.fifo_full  = full_req && (rd_ptr == 0);
    assign fif.fifo_empty = (rd_ptr >= n_words);

    always @(posedge rclk) begin
        if (fifo_clr) rd_ptr <= 0;
        else if (fif.rden) begin
            fif.fifo_dout <= mem[rd_ptr[2:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // event monitors
    int   rden_cnt = 0, done_cnt = 0, cap_hi_cnt = 0, cap_rise_cnt = 0, idle_bad_cnt = 0;
    logic cap_prev = 1'b0;

    always @(negedge rclk) begin
        if (fif.rden === 1'b1) rden_cnt <= rden_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (fif.cap_en === 1'b1) cap_hi_cnt <= cap_hi_cnt + 1;
        if (fif.cap_en === 1'b1 && !cap_prev) cap_rise_cnt <= cap_rise_cnt + 1;
        cap_prev <= (fif.cap_en === 1'b1);
        if (uart_tx !== 1'b1 || fif.cap_en !== 1'b0 || busy !== 1'b0)
            idle_bad_cnt <= idle_bad_cnt + 1;
    end

    // UART decoder and scoreboard consumer
    logic [7:0] exp_q [$];
    logic       dec_en = 1'b0;
    int         bytes_started = 0;
    int         extra_bytes = 0;

    initial begin : decoder
        logic [9:0] bits;
        logic       stable;
        forever begin
            @(negedge rclk);
            if (dec_en && uart_tx === 1'b0) begin
                bytes_started++;
                stable = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < 10; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge rclk);
                        if (s == 0) bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (dec_en) begin
                    // {start==0, stop==1, every bit held exactly 10 cycles}
                    check("framing", {29'd0, !bits[0], bits[9], stable}, 32'd7);
                    if (exp_q.size() != 0) check("byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
                    else extra_bytes++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic load_fifo(input int nw, input bit fixed);
        for (int i = 0; i < 8; i++)
            mem[i] = fixed ? {8'(2*i+1), 8'(2*i+2)} : 16'($urandom);
        n_words  = nw;
        full_req = 1'b0;
        fifo_clr = 1'b1;
        tick(1);
        fifo_clr = 1'b0;
    endtask

    // expected stream: header, sent words high byte first, trailer, XOR of all after header
    task automatic push_frame(input int nw);
        int         sent;
        logic [7:0] x;
        sent = (nw < NS) ? nw : NS;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < sent; i++) begin
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
            x = x ^ mem[i][15:8] ^ mem[i][7:0];
        end
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(sent >> 8));
        exp_q.push_back(8'(sent));
        x = x ^ 8'h5A ^ 8'(sent >> 8) ^ 8'(sent);
        exp_q.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_cap_en();
        int t = 0;
        while (fif.cap_en !== 1'b1 && t < 10) begin tick(1); t++; end
        check("cap_en_rise", {31'd0, fif.cap_en}, 32'd1);
    endtask

    task automatic run_frame(input int nw, input int full_delay, input bit restart);
        int d0, r0, c0, cr0, e0, t;
        d0 = done_cnt; r0 = rden_cnt; c0 = cap_hi_cnt; cr0 = cap_rise_cnt; e0 = extra_bytes;
        push_frame(nw);
        pulse_start();
        check("busy_on_start", {31'd0, busy}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
        wait_cap_en();
        tick(full_delay);
        full_req = 1'b1;
        if (restart) begin
            tick(200);
            pulse_start();
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin tick(1); t++; end
        full_req = 1'b0;
        tick(5);
        check("done_pulses", done_cnt - d0, 1);
        check("cap_en_cycles", cap_hi_cnt - c0, full_delay + 1);
        check("cap_en_rises", cap_rise_cnt - cr0, 1);
        check("rden_pulses", rden_cnt - r0, (nw < NS) ? nw : NS);
        check("err_after_done", {31'd0, err}, (nw < NS) ? 32'd1 : 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("bytes_left", exp_q.size(), 0);
        check("extra_bytes", extra_bytes - e0, 0);
    endtask

    initial begin
        int b0, r0, t;
        // reset
        tick(3);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_cap_en", {31'd0, fif.cap_en}, 32'd0);
        check("rst_rden", {31'd0, fif.rden}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        mr = 1'b1;
        dec_en = 1'b1;
        b0 = idle_bad_cnt; r0 = rden_cnt;
        tick(100);
        check("idle_quiet", idle_bad_cnt - b0, 0);
        check("idle_no_rden", rden_cnt - r0, 0);

        // nominal frame with known words
        load_fifo(4, 1'b1);
        run_frame(4, 20, 1'b0);

        // underrun after two words
        load_fifo(2, 1'b0);
        run_frame(2, 7, 1'b0);

        // err clears on next start; second start while busy is ignored
        load_fifo(4, 1'b0);
        run_frame(4, 3, 1'b1);
        tick(50);
        check("no_restart", cap_rise_cnt, 3);

        // reset during third data byte
        load_fifo(4, 1'b0);
        push_frame(4);
        pulse_start();
        wait_cap_en();
        tick(5);
        full_req = 1'b1;
        b0 = bytes_started;
        t = 0;
        while (bytes_started - b0 < 4 && t < 2000) begin tick(1); t++; end
        check("reached_byte3", bytes_started - b0, 4);
        tick(30);
        dec_en = 1'b0;
        r0 = rden_cnt;
        mr = 1'b0;
        #1;
        check("mr_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cap_en", {31'd0, fif.cap_en}, 32'd0);
        exp_q.delete();
        full_req = 1'b0;
        tick(4);
        mr = 1'b1;
        tick(120);
        check("mr_no_rden", rden_cnt - r0, 0);
        dec_en = 1'b1;
        load_fifo(4, 1'b0);
        run_frame(4, 11, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
